// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU command issuer.
// Opcodes, register map, holdoff counts, FSM state and byte-lane merge.
package gpu_pkg;

  localparam int GPU_OP_POS = 12;

  localparam logic [3:0] GPU_OP_DATA_READ   = 4'd0;
  localparam logic [3:0] GPU_OP_DATA_WRITE  = 4'd1;
  localparam logic [3:0] GPU_OP_MUL_MAT_VEC = 4'd2;

  localparam logic [2:0] REG_CMD      = 3'd0;
  localparam logic [2:0] REG_WDATA_LO = 3'd1;
  localparam logic [2:0] REG_WDATA_HI = 3'd2;
  localparam logic [2:0] REG_RDATA_LO = 3'd3;
  localparam logic [2:0] REG_RDATA_HI = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  localparam logic [2:0] MUL_HOLDOFF   = 3'd4;
  localparam logic [2:0] RESET_HOLDOFF = 3'd2;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } issue_state_e;

  function automatic logic [3:0] op_of(
    input logic [31:0] cmd
  );
    return cmd[GPU_OP_POS +: 4];
  endfunction

  function automatic logic [31:0] sel_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO, 96-bit entries {data[63:0], cmd[31:0]}.
// Ports: clk_i/rst_i, push_i/din_i, pop_i/dout_o, full_o, empty_o, count_o.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [95:0]              din_i,
  input  logic                     pop_i,
  output logic [95:0]              dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;
  logic          do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the head slot in the same edge, so a
  // push against a full FIFO is still taken.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/gpu_cmd_issuer.sv
// Wishbone slave that queues command words and issues them to gpu_core.
// Ports: wbs_* Wishbone slave; gpu_command_o/gpu_data_o/gpu_stb_o, gpu_ack_i/gpu_data_i core side.
module gpu_cmd_issuer
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [31:0] gpu_command_o,
  output logic [63:0] gpu_data_o,
  input  logic [63:0] gpu_data_i,
  output logic        gpu_stb_o,
  input  logic        gpu_ack_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ack_q;
  logic [31:0]   dat_q;
  logic [63:0]   wdata_q;
  logic          ovf_q;

  issue_state_e  state_q;
  logic [2:0]    hold_q;
  logic          stb_q;
  logic [31:0]   cmd_q;
  logic [63:0]   data_q;
  logic [63:0]   rdata_q;
  logic          rvalid_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [95:0]   fifo_dout;

  logic          wb_acc;
  logic          wb_wr;
  logic          wb_rd;
  logic [2:0]    idx;
  logic          push;
  logic          pop;
  logic          status_clr;
  logic          busy;
  logic [7:0]    cnt8;
  logic [31:0]   status;
  logic [31:0]   rd_mux;
  logic          unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  // ~ack_q keeps the ack a single-cycle pulse while the
  // master still holds stb in the ack cycle.
  assign wb_acc = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wb_wr  = wb_acc & wbs_we_i;
  assign wb_rd  = wb_acc & ~wbs_we_i;
  assign idx    = wbs_adr_i[4:2];

  assign push       = wb_wr && (idx == REG_CMD);
  assign status_clr = wb_wr && (idx == REG_STATUS);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

  assign cnt8   = 8'(fifo_cnt);
  assign status = {16'h0, cnt8, 3'b000, ovf_q,
                   rvalid_q, busy, fifo_full, fifo_empty};

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push),
    .din_i   ({wdata_q, wbs_dat_i}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    rd_mux = '0;
    unique case (idx)
      REG_WDATA_LO: rd_mux = wdata_q[31:0];
      REG_WDATA_HI: rd_mux = wdata_q[63:32];
      REG_RDATA_LO: rd_mux = rdata_q[31:0];
      REG_RDATA_HI: rd_mux = rdata_q[63:32];
      REG_STATUS:   rd_mux = status;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ack_q <= wb_acc;
      if (wb_rd) dat_q <= rd_mux;
      if (wb_wr) begin
        unique case (idx)
          REG_WDATA_LO:
            wdata_q[31:0] <= sel_merge(
              wdata_q[31:0], wbs_dat_i, wbs_sel_i);
          REG_WDATA_HI:
            wdata_q[63:32] <= sel_merge(
              wdata_q[63:32], wbs_dat_i, wbs_sel_i);
          REG_STATUS:
            ovf_q <= 1'b0;
          REG_CMD:
            if (fifo_full && !pop) ovf_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_HOLD;
      hold_q   <= RESET_HOLDOFF;
      stb_q    <= 1'b0;
      cmd_q    <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (status_clr) rvalid_q <= 1'b0;
      unique case (state_q)
        ST_HOLD: begin
          // Leave on the cycle the count would hit zero,
          // so a holdoff of N spends exactly N cycles here.
          if (hold_q <= 3'd1) begin
            hold_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_q - 3'd1;
          end
        end
        ST_IDLE: begin
          if (!fifo_empty) begin
            cmd_q   <= fifo_dout[31:0];
            data_q  <= fifo_dout[95:32];
            stb_q   <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          stb_q   <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (gpu_ack_i) begin
            unique case (op_of(cmd_q))
              GPU_OP_DATA_READ: begin
                rdata_q  <= gpu_data_i;
                rvalid_q <= 1'b1;
                state_q  <= ST_IDLE;
              end
              GPU_OP_MUL_MAT_VEC: begin
                hold_q  <= MUL_HOLDOFF;
                state_q <= ST_HOLD;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign gpu_stb_o     = stb_q;
  assign gpu_command_o = cmd_q;
  assign gpu_data_o    = data_q;

endmodule
